// File: rtl/crc_frame_tx.sv
// Streaming CRC transmitter: forwards up to FRAME_LEN data beats, then appends
// one CRC beat (m_last=1) computed MSB-first over every forwarded beat.
module crc_frame_tx #(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          CRC_WIDTH  = 32,
    parameter logic [CRC_WIDTH-1:0] POLY       = CRC_WIDTH'(32'h04C11DB7),
    parameter logic [CRC_WIDTH-1:0] INIT       = '1,
    parameter logic [CRC_WIDTH-1:0] XOR_OUT    = '1,
    parameter int unsigned          FRAME_LEN  = 5
) (
    input  logic                  axis_aclk,
    input  logic                  axis_aresetn,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  frame_ready,
    output logic                  crc_busy
);

    localparam int unsigned          CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_DATA,
        ST_CRC,
        ST_WAIT
    } state_e;

    function automatic logic [CRC_WIDTH-1:0] crc_next(
        input logic [CRC_WIDTH-1:0]  crc_in,
        input logic [DATA_WIDTH-1:0] data
    );
        logic [CRC_WIDTH-1:0] c;
        logic                 fb;
        c = crc_in;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            fb = c[CRC_WIDTH-1] ^ data[i];
            c  = (c << 1) ^ (fb ? POLY : '0);
        end
        return c;
    endfunction

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CRC_WIDTH-1:0]  crc_q, crc_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;
    logic                  frame_ready_q, frame_ready_d;
    logic                  crc_busy_q, crc_busy_d;

    logic m_hs;
    logic free;

    assign m_hs = m_valid_q & m_ready;
    assign free = ~m_valid_q | m_ready;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        crc_d         = crc_q;
        m_data_d      = m_data_q;
        m_valid_d     = m_valid_q;
        m_last_d      = m_last_q;
        frame_ready_d = 1'b0;
        crc_busy_d    = crc_busy_q;
        s_ready       = 1'b0;

        // A consumed beat empties the output register unless a new beat reloads it below.
        if (m_hs) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        unique case (state_q)
            ST_DATA: begin
                s_ready = free;
                if (s_valid && free) begin
                    m_data_d  = s_data;
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b0;
                    crc_d     = crc_next(crc_q, s_data);
                    if (cnt_q == LAST_CNT || s_last) begin
                        state_d    = ST_CRC;
                        crc_busy_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_CRC: begin
                if (free) begin
                    m_data_d                  = '0;
                    m_data_d[CRC_WIDTH-1:0]   = crc_q ^ XOR_OUT;
                    m_valid_d                 = 1'b1;
                    m_last_d                  = 1'b1;
                    state_d                   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (m_hs) begin
                    frame_ready_d = 1'b1;
                    crc_d         = INIT;
                    cnt_d         = '0;
                    crc_busy_d    = 1'b0;
                    state_d       = ST_DATA;
                end
            end
            default: state_d = ST_DATA;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; comb logic above uses blocking.
    always_ff @(posedge axis_aclk or posedge axis_aresetn) begin
        if (axis_aresetn) begin
            state_q       <= ST_DATA;
            cnt_q         <= '0;
            crc_q         <= INIT;
            m_data_q      <= '0;
            m_valid_q     <= 1'b0;
            m_last_q      <= 1'b0;
            frame_ready_q <= 1'b0;
            crc_busy_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            crc_q         <= crc_d;
            m_data_q      <= m_data_d;
            m_valid_q     <= m_valid_d;
            m_last_q      <= m_last_d;
            frame_ready_q <= frame_ready_d;
            crc_busy_q    <= crc_busy_d;
        end
    end

    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign m_last      = m_last_q;
    assign frame_ready = frame_ready_q;
    assign crc_busy    = crc_busy_q;

endmodule

// File: tb/tb_crc_frame_tx.sv
// Scoreboard bench for crc_frame_tx: four parameterisations share one clock;
// the driver pushes expected beats, a negedge monitor pops and compares them.
module tb_crc_frame_tx;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic d_rst;

    logic [31:0] s_data   [4];
    logic        s_valid  [4];
    logic        s_last   [4];
    logic        m_ready  [4];
    logic [31:0] mon_data [4];
    logic        s_ready  [4];
    logic        m_valid  [4];
    logic        m_last   [4];
    logic        frame_ready [4];
    logic        crc_busy [4];
    logic [7:0]  a_m_data;
    logic [31:0] b_m_data, c_m_data, d_m_data;

    assign mon_data[0] = {24'h0, a_m_data};
    assign mon_data[1] = b_m_data;
    assign mon_data[2] = c_m_data;
    assign mon_data[3] = d_m_data;

    // 0: CRC-8 over ASCII, 1: FRAME_LEN=1 zero init, 2: FRAME_LEN=1 defaults, 3: defaults
    crc_frame_tx #(.DATA_WIDTH(8), .CRC_WIDTH(8), .POLY(8'h07), .INIT(8'h00),
                   .XOR_OUT(8'h00), .FRAME_LEN(9)) u_a (
        .axis_aclk(clk), .axis_aresetn(rst), .s_data(s_data[0][7:0]), .s_valid(s_valid[0]),
        .s_last(s_last[0]), .s_ready(s_ready[0]), .m_data(a_m_data), .m_valid(m_valid[0]),
        .m_last(m_last[0]), .m_ready(m_ready[0]), .frame_ready(frame_ready[0]),
        .crc_busy(crc_busy[0]));

    crc_frame_tx #(.INIT(32'h0), .XOR_OUT(32'h0), .FRAME_LEN(1)) u_b (
        .axis_aclk(clk), .axis_aresetn(rst), .s_data(s_data[1]), .s_valid(s_valid[1]),
        .s_last(s_last[1]), .s_ready(s_ready[1]), .m_data(b_m_data), .m_valid(m_valid[1]),
        .m_last(m_last[1]), .m_ready(m_ready[1]), .frame_ready(frame_ready[1]),
        .crc_busy(crc_busy[1]));

    crc_frame_tx #(.FRAME_LEN(1)) u_c (
        .axis_aclk(clk), .axis_aresetn(rst), .s_data(s_data[2]), .s_valid(s_valid[2]),
        .s_last(s_last[2]), .s_ready(s_ready[2]), .m_data(c_m_data), .m_valid(m_valid[2]),
        .m_last(m_last[2]), .m_ready(m_ready[2]), .frame_ready(frame_ready[2]),
        .crc_busy(crc_busy[2]));

    crc_frame_tx u_d (
        .axis_aclk(clk), .axis_aresetn(rst | d_rst), .s_data(s_data[3]), .s_valid(s_valid[3]),
        .s_last(s_last[3]), .s_ready(s_ready[3]), .m_data(d_m_data), .m_valid(m_valid[3]),
        .m_last(m_last[3]), .m_ready(m_ready[3]), .frame_ready(frame_ready[3]),
        .crc_busy(crc_busy[3]));

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t sb_q [4][$];
    logic [31:0] model_crc;
    bit    tog_en = 1'b0;
    int    cyc = 0;
    int    fr_cyc [$];
    int    last_cnt = 0;

    bit          exp_fr    [4];
    bit          stall     [4];
    logic [31:0] prev_data [4];
    logic        prev_last [4];
    beat_t       mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name, input string what);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Reference CRC-32 step for the default instance, written straight from the bit-serial definition.
    function automatic logic [31:0] crc32_step(input logic [31:0] c_in, input logic [31:0] d);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int b = 31; b >= 0; b--) begin
            fb = c[31] ^ d[b];
            c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
        end
        return c;
    endfunction

    task automatic push(input int i, input logic [31:0] d, input logic last);
        beat_t b;
        b.data = d;
        b.last = last;
        sb_q[i].push_back(b);
    endtask

    task automatic send(input int i, input logic [31:0] d, input logic last);
        logic rdy;
        bit   done;
        done        = 1'b0;
        s_data[i]   = d;
        s_last[i]   = last;
        s_valid[i]  = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            rdy = s_ready[i];
            @(posedge clk);
            if (rdy) done = 1'b1;
        end
        if (done) begin
            push(i, d, 1'b0);
            if (i == 3) model_crc = crc32_step(model_crc, d);
        end else begin
            flag_fail($sformatf("send_timeout[%0d]", i), "s_ready never asserted");
        end
        #1;
        s_valid[i] = 1'b0;
        s_last[i]  = 1'b0;
    endtask

    task automatic push_crc_d();
        push(3, ~model_crc, 1'b1);
        model_crc = '1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int i);
        for (int t = 0; t < 200 && sb_q[i].size() != 0; t++) @(posedge clk);
        if (sb_q[i].size() != 0)
            flag_fail($sformatf("drain_timeout[%0d]", i), $sformatf("%0d beats outstanding", sb_q[i].size()));
        idle(3);
    endtask

    task automatic check_zero(input int i, input string tag);
        check($sformatf("%s_m_data[%0d]", tag, i), mon_data[i], 32'h0);
        check($sformatf("%s_m_valid[%0d]", tag, i), 32'(m_valid[i]), 32'h0);
        check($sformatf("%s_m_last[%0d]", tag, i), 32'(m_last[i]), 32'h0);
        check($sformatf("%s_frame_ready[%0d]", tag, i), 32'(frame_ready[i]), 32'h0);
        check($sformatf("%s_crc_busy[%0d]", tag, i), 32'(crc_busy[i]), 32'h0);
    endtask

    // m_ready for instance 3 toggles every cycle while tog_en is set, otherwise stays high.
    always begin
        @(posedge clk);
        #1;
        m_ready[3] = tog_en ? ~m_ready[3] : 1'b1;
    end

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (rst || (i == 3 && d_rst)) begin
                exp_fr[i] = 1'b0;
                stall[i]  = 1'b0;
                continue;
            end
            check($sformatf("frame_ready[%0d]", i), 32'(frame_ready[i]), 32'(exp_fr[i]));
            if (i == 3 && frame_ready[i]) fr_cyc.push_back(cyc);
            if (stall[i]) begin
                check($sformatf("stall_valid[%0d]", i), 32'(m_valid[i]), 32'h1);
                check($sformatf("stall_data[%0d]", i), mon_data[i], prev_data[i]);
                check($sformatf("stall_last[%0d]", i), 32'(m_last[i]), 32'(prev_last[i]));
            end
            if (m_valid[i] && m_last[i]) begin
                check($sformatf("s_ready_in_crc[%0d]", i), 32'(s_ready[i]), 32'h0);
                check($sformatf("crc_busy_in_crc[%0d]", i), 32'(crc_busy[i]), 32'h1);
            end
            if (m_valid[i] && m_ready[i]) begin
                if (sb_q[i].size() == 0) begin
                    flag_fail($sformatf("unexpected_beat[%0d]", i),
                              $sformatf("got %h last=%0b, expected none", mon_data[i], m_last[i]));
                end else begin
                    mon_exp = sb_q[i].pop_front();
                    check($sformatf("beat_data[%0d]", i), mon_data[i], mon_exp.data);
                    check($sformatf("beat_last[%0d]", i), 32'(m_last[i]), 32'(mon_exp.last));
                end
                if (i == 3 && m_last[i]) last_cnt++;
            end
            exp_fr[i]    = m_valid[i] && m_ready[i] && m_last[i];
            stall[i]     = m_valid[i] && !m_ready[i];
            prev_data[i] = mon_data[i];
            prev_last[i] = m_last[i];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        d_rst     = 1'b0;
        model_crc = '1;
        for (int i = 0; i < 4; i++) begin
            s_data[i]  = '0;
            s_valid[i] = 1'b0;
            s_last[i]  = 1'b0;
            m_ready[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) check_zero(i, "reset");
        rst = 1'b0;
        idle(1);

        // CRC-8 (poly 07) of "123456789" is F4
        for (int k = 0; k < 9; k++) send(0, 32'h31 + k, 1'b0);
        push(0, 32'hF4, 1'b1);
        drain(0);

        // FRAME_LEN=1: each beat is followed by its own CRC
        send(1, 32'h00000001, 1'b0);
        push(1, 32'h04C11DB7, 1'b1);
        send(1, 32'h00000001, 1'b0);
        push(1, 32'h04C11DB7, 1'b1);
        send(2, 32'hFFFFFFFF, 1'b0);
        push(2, 32'hFFFFFFFF, 1'b1);
        drain(1);
        drain(2);

        // full frame under m_ready toggling
        tog_en = 1'b1;
        send(3, 5, 1'b0);
        send(3, 3, 1'b0);
        send(3, 678, 1'b0);
        send(3, 76, 1'b0);
        send(3, 89, 1'b0);
        push_crc_d();
        drain(3);
        tog_en = 1'b0;
        idle(2);

        // early s_last, then a full frame with s_valid gaps
        send(3, 5, 1'b0);
        send(3, 3, 1'b1);
        push_crc_d();
        send(3, 5, 1'b0);
        idle(2);
        send(3, 3, 1'b0);
        send(3, 678, 1'b0);
        idle(1);
        send(3, 76, 1'b0);
        send(3, 89, 1'b0);
        push_crc_d();
        drain(3);

        // reset mid-frame discards the partial frame
        send(3, 5, 1'b0);
        send(3, 3, 1'b0);
        send(3, 678, 1'b0);
        d_rst = 1'b1;
        #1;
        check_zero(3, "midreset");
        sb_q[3].delete();
        model_crc = '1;
        idle(2);
        d_rst = 1'b0;
        idle(1);
        send(3, 5, 1'b0);
        send(3, 3, 1'b0);
        send(3, 678, 1'b0);
        send(3, 76, 1'b0);
        send(3, 89, 1'b0);
        push_crc_d();
        drain(3);

        // two frames back-to-back
        fr_cyc.delete();
        last_cnt = 0;
        for (int f = 0; f < 2; f++) begin
            send(3, 5, 1'b0);
            send(3, 3, 1'b0);
            send(3, 678, 1'b0);
            send(3, 76, 1'b0);
            send(3, 89, 1'b0);
            push_crc_d();
        end
        drain(3);
        check("b2b_last_count", 32'(last_cnt), 32'd2);
        check("b2b_frame_ready_count", 32'(fr_cyc.size()), 32'd2);
        if (fr_cyc.size() == 2)
            check("b2b_frame_ready_gap", 32'(fr_cyc[1] - fr_cyc[0]), 32'd7);

        for (int i = 0; i < 4; i++)
            check($sformatf("sb_empty[%0d]", i), 32'(sb_q[i].size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/crc_frame_tx.md
Name: crc_frame_tx

Overview:
- Parametrised streaming CRC transmitter and successor to the fixed-width CRC transmit block.
- Forwards a frame of data beats from an AXI-Stream-style slave port to a master port with backpressure.
- After the final data beat, appends one CRC beat and marks it with m_last.
- Polynomial, init, output XOR, data width and frame length are generics; s_last terminates a frame early.

Parameters:
DATA_WIDTH, 32, data beat width in bits
CRC_WIDTH, 32, CRC width; legal range 1..DATA_WIDTH
POLY, 32'h04C11DB7, generator polynomial, implicit x^CRC_WIDTH term omitted
INIT, all ones, CRC register value at frame start
XOR_OUT, all ones, XOR applied to the CRC before transmission
FRAME_LEN, 5, maximum data beats per frame (>=1)

Ports:
axis_aclk  in  1  clock, rising edge
axis_aresetn  in  1  reset, asynchronous, active-high (1 = in reset)
s_data  in  DATA_WIDTH  input beat
s_valid  in  1  input beat valid
s_last  in  1  input beat ends frame early; sampled with s_data
s_ready  out  1  block accepts input beat this cycle
m_data  out  DATA_WIDTH  output beat, data or CRC
m_valid  out  1  output beat valid
m_last  out  1  output beat is the CRC beat
m_ready  in  1  downstream accepts output beat
frame_ready  out  1  one-cycle pulse: frame fully transmitted
crc_busy  out  1  CRC beat pending or in flight

Behaviour:
- Reset (async assert, sync release):
  - m_data=0, m_valid=0, m_last=0, frame_ready=0, crc_busy=0.
  - State=DATA, beat count=0, CRC register=INIT.
  - Reset mid-frame discards the partial frame; no CRC beat is emitted.
- Handshakes:
  - s_hs = s_valid & s_ready; m_hs = m_valid & m_ready.
  - m_data/m_valid/m_last are registered outputs and hold stable while m_valid & !m_ready.
- Output register free: free = !m_valid | m_ready.
- State DATA:
  - s_ready = free.
  - On s_hs: m_data<=s_data, m_valid<=1, m_last<=0, CRC register updated, count++.
  - If count==FRAME_LEN-1 or s_last: go to CRC, crc_busy<=1.
- State CRC:
  - s_ready=0.
  - When free: m_data<={zero-extend, crc^XOR_OUT} with CRC in the LSBs, m_valid<=1, m_last<=1; go to WAIT.
- State WAIT:
  - s_ready=0.
  - On m_hs: frame_ready<=1 for exactly one cycle; m_valid<=0 unless reloaded, else m_valid<=0.
  - Also on m_hs: CRC register<=INIT, count<=0, crc_busy<=0, go to DATA.
- frame_ready is otherwise 0.
- No-handshake output clear: in any state, m_hs with no new load clears m_valid.
- CRC update:
  - MSB-first, non-reflected.
  - For i = DATA_WIDTH-1 downto 0: fb = crc[CRC_WIDTH-1]^d[i]; crc = (crc<<1) ^ (fb ? POLY : 0), truncated to CRC_WIDTH.
  - Fully combinational within one cycle.
- Latency:
  - Data beat appears on m_data 1 cycle after s_hs.
  - With m_ready=1 throughout, the CRC beat directly follows the last data beat (1 cycle).
  - frame_ready rises 1 cycle after the CRC m_hs.
  - Throughput is FRAME_LEN+2 cycles per full frame.
- Boundary conditions:
  - FRAME_LEN=1: every accepted beat is followed by a CRC beat.
  - s_last on beat 1: frame of 1 data beat.
  - s_valid held during CRC/WAIT is ignored (s_ready=0); no beat is lost.
  - m_ready low holds the CRC beat indefinitely with m_last=1 stable.
  - s_valid may drop mid-frame; count and CRC hold.

Test Plan:
1. DATA_WIDTH=8, CRC_WIDTH=8, POLY=8'h07, INIT=0, XOR_OUT=0, FRAME_LEN=9; send ASCII "123456789", m_ready=1 -> m_data 8'h31..8'h39, then 8'hF4 with m_last=1; frame_ready pulse 1 cycle later.
2. Defaults, FRAME_LEN=1, INIT=0, XOR_OUT=0; send 32'h00000001 -> CRC beat 32'h04C11DB7. Repeat with INIT=all ones, XOR_OUT=all ones, data 32'hFFFFFFFF -> CRC beat 32'hFFFFFFFF.
3. Defaults; send 5,3,678,76,89 back-to-back with m_ready toggling 1/0 each cycle -> same 6-beat output sequence and CRC as with m_ready=1; m_data stable while stalled; s_ready low during the CRC beat.
4. Defaults; send 5,3 with s_last on beat 2 -> output 5,3,CRC; count resets. Next frame 5,3,678,76,89 CRC is identical to scenario 3 (CRC re-initialised).
5. Assert reset mid-frame after 3 beats -> all outputs 0 immediately; after release, a full frame gives the scenario-3 CRC and no stale CRC beat appears.
6. Two full frames back-to-back with m_ready=1 -> exactly two m_last beats and two frame_ready pulses, 7 cycles apart.
